// File: rtl/muldiv_stall_ctrl.sv
// rtl/muldiv_stall_ctrl.sv - iterative RV32M multiply/divide sequencer with pipeline stall control
module muldiv_stall_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mdu_en_EX,
    input  logic [2:0]      funct3_EX,
    input  logic [XLEN-1:0] rs1_val_EX,
    input  logic [XLEN-1:0] rs2_val_EX,
    input  logic [4:0]      rd_EX,
    input  logic            flush_EX,
    output logic            stall_mdu,
    output logic            result_valid,
    output logic [XLEN-1:0] result_out,
    output logic [4:0]      rd_out,
    output logic            busy
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   op_q, op_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2:0]        f3_q, f3_d;
    logic [4:0]        rd_q, rd_d;
    logic              neg_q, neg_d;
    logic              spec_q, spec_d;
    logic [XLEN-1:0]   res_q, res_d;

    logic              launch;
    logic              signed_a, signed_b, a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   spec_val;
    logic [XLEN-1:0]   addend;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     rem_sh, diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res, div_raw, div_res, final_res;

    assign launch = (state_q == S_IDLE) && mdu_en_EX && !flush_EX;

    // Launch-time operand conditioning: magnitudes, result sign and special cases
    always_comb begin
        signed_a = (funct3_EX == 3'b001) || (funct3_EX == 3'b010) || (funct3_EX[2] && !funct3_EX[0]);
        signed_b = (funct3_EX == 3'b001) || (funct3_EX[2] && !funct3_EX[0]);
        a_neg    = signed_a && rs1_val_EX[XLEN-1];
        b_neg    = signed_b && rs2_val_EX[XLEN-1];
        mag_a    = a_neg ? -rs1_val_EX : rs1_val_EX;
        mag_b    = b_neg ? -rs2_val_EX : rs2_val_EX;
        div_zero = funct3_EX[2] && (rs2_val_EX == {XLEN{1'b0}});
        div_ovf  = funct3_EX[2] && !funct3_EX[0]
                   && (rs1_val_EX == {1'b1, {(XLEN-1){1'b0}}})
                   && (rs2_val_EX == {XLEN{1'b1}});
        if (div_zero) begin
            spec_val = funct3_EX[1] ? rs1_val_EX : {XLEN{1'b1}};
        end else begin
            spec_val = funct3_EX[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // One iteration step: shift-add multiply or restoring divide on acc_q
    always_comb begin
        addend   = acc_q[0] ? op_q : {XLEN{1'b0}};
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, addend};
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        diff     = rem_sh - {1'b0, op_q};
        if (diff[XLEN]) begin
            div_next = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            div_next = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
    end

    always_comb begin
        prod      = neg_q ? -acc_q : acc_q;
        mul_res   = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        div_raw   = f3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        div_res   = neg_q ? -div_raw : div_raw;
        final_res = spec_q ? acc_q[XLEN-1:0] : (f3_q[2] ? div_res : mul_res);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        neg_d   = neg_q;
        spec_d  = spec_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    f3_d  = funct3_EX;
                    rd_d  = rd_EX;
                    neg_d = (funct3_EX[2] && funct3_EX[1]) ? a_neg : (a_neg ^ b_neg);
                    if (div_zero || div_ovf) begin
                        spec_d  = 1'b1;
                        acc_d   = {{XLEN{1'b0}}, spec_val};
                        state_d = S_DONE;
                    end else begin
                        spec_d  = 1'b0;
                        op_d    = funct3_EX[2] ? mag_b : mag_a;
                        acc_d   = {{XLEN{1'b0}}, (funct3_EX[2] ? mag_a : mag_b)};
                        cnt_d   = CW'(XLEN-1);
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (flush_EX) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = f3_q[2] ? div_next : mul_next;
                    if (cnt_q == {CW{1'b0}}) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            S_DONE: begin
                // The EX op is still present here, so mdu_en_EX must not relaunch it
                res_d   = final_res;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            neg_q   <= 1'b0;
            spec_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            neg_q   <= neg_d;
            spec_q  <= spec_d;
            res_q   <= res_d;
        end
    end

    assign stall_mdu    = launch || ((state_q == S_BUSY) && !flush_EX);
    assign busy         = (state_q == S_BUSY);
    assign result_valid = (state_q == S_DONE);
    assign result_out   = (state_q == S_DONE) ? final_res : res_q;
    assign rd_out       = rd_q;

endmodule

// File: doc/muldiv_stall_ctrl.md
Name: muldiv_stall_ctrl

Overview:
Iterative RV32M multiply/divide sequencer in the EX stage. It accepts an M-extension op from EX and runs a radix-2 shift-add multiply or restoring divide over XLEN cycles. While the op runs it holds the pipeline through a stall output, which is ORed into the PC/IF-ID/ID-EX stall controls. It returns the result with a one-cycle valid pulse, and it aborts cleanly on a branch/jump flush of EX.

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
mdu_en_EX  input  1  EX holds a valid M-extension op (opcode 0110011, funct7 0000001).
funct3_EX  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
rs1_val_EX  input  XLEN  operand A, already forwarded.
rs2_val_EX  input  XLEN  operand B, already forwarded.
rd_EX  input  5  destination register of the EX op.
flush_EX  input  1  EX instruction is being killed (taken branch/jump).
stall_mdu  output  1  hold PC, IF/ID and ID/EX this cycle.
result_valid  output  1  one-cycle pulse; result_out is valid.
result_out  output  XLEN  final result.
rd_out  output  5  rd latched at launch.
busy  output  1  state is BUSY.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (sync, rst=1): state IDLE, counter 0, all datapath registers 0. Outputs stall_mdu=0, result_valid=0, result_out=0, rd_out=0, busy=0. Reset overrides everything, including an op in progress.
- Launch condition: IDLE & mdu_en_EX & !flush_EX. In that cycle stall_mdu=1 (combinational), and the operands, funct3 and rd are latched.
  - Normal op: go to BUSY, counter loads XLEN-1.
  - Special case: go straight to DONE.
- IDLE with flush_EX=1 or mdu_en_EX=0: no launch, stall_mdu=0.
- Multiply:
  - Operands are converted to magnitudes. rs1 is treated as signed for MULH and MULHSU. rs2 is treated as signed for MULH only.
  - One shift-add step per BUSY cycle builds a 2*XLEN unsigned product.
  - The product is negated in DONE if the operand signs differ.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- Divide:
  - Magnitude restoring division, one quotient bit per BUSY cycle.
  - Quotient sign = sign(A) xor sign(B), for signed ops only.
  - Remainder sign = sign(A), for signed ops only.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases (detected at launch, DONE on the next cycle):
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - Signed overflow (A=0x80000000, B=-1, DIV/REM): quotient 0x80000000, remainder 0.
- BUSY:
  - stall_mdu=1 and busy=1.
  - The counter decrements each cycle; the cycle that sees counter==0 transitions to DONE.
  - Normal latency: launch cycle T, BUSY T+1..T+XLEN, DONE T+XLEN+1. stall_mdu is high T..T+XLEN (XLEN+1 cycles).
- DONE (exactly one cycle):
  - result_valid=1, result_out and rd_out valid, stall_mdu=0.
  - The pipeline advances, and the EX instruction consumes result_out.
  - mdu_en_EX is ignored in DONE (same instruction still present), so there is no relaunch.
  - Next state is IDLE; result_out holds its value until the next DONE.
- Back-to-back M ops: the next op is in EX in the cycle after DONE and launches from IDLE. There is no bubble beyond the DONE cycle.
- flush_EX in BUSY: abort. Next state is IDLE, no result_valid, and stall_mdu drops in that same cycle so the flush can proceed.
- flush_EX in DONE: result_valid still pulses. The pipeline discards it.
- rd_EX=0: the op executes normally; write suppression is the writeback stage's job.

Test Plan:
1. MUL 7 × 0xFFFFFFFD (-3), launched at cycle T:
   - stall_mdu high T..T+32.
   - result_valid at T+33 only.
   - result_out=0xFFFFFFEB, rd_out equals the launched rd.
2. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF. MULH 0x80000000 × 0x80000000 -> 0x40000000.
3. DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU -> 2.
4. Special cases, each with result_valid at T+1 and stall_mdu high only at T:
   - DIVU 5/0 -> 0xFFFFFFFF.
   - REM 5/0 -> 5.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
   - REM 0x80000000/0xFFFFFFFF -> 0.
5. Abort and reset:
   - flush_EX at the 10th BUSY cycle -> IDLE next cycle, stall_mdu=0 that cycle, no result_valid.
   - rst at the 5th BUSY cycle -> all outputs 0 next cycle.
6. Two consecutive MULs with mdu_en_EX held across DONE:
   - Second launch occurs exactly at the cycle after DONE, not in DONE.
   - Two result_valid pulses 34 cycles apart.
